// File: rtl/at25010_interface_pkg.sv
// Shared definitions for the AT25010 SPI master: abstract command codes,
// EEPROM instruction opcodes and the frame-sequencing FSM state encoding.
package at25010_interface_pkg;

  typedef enum logic [2:0] {
    CMD_WREN  = 3'b000,
    CMD_WRDI  = 3'b001,
    CMD_RDSR  = 3'b010,
    CMD_WRSR  = 3'b011,
    CMD_READ  = 3'b100,
    CMD_WRITE = 3'b101
  } cmd_e;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  // Frame lengths in SCLK bits
  localparam logic [4:0] LEN_OP    = 5'd8;
  localparam logic [4:0] LEN_OP_B1 = 5'd16;
  localparam logic [4:0] LEN_OP_B2 = 5'd24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_CS_GAP,
    ST_ERR
  } state_e;

  // Commands whose trailing byte is read back from MISO
  function automatic logic is_read_cmd(input cmd_e c);
    return (c == CMD_RDSR) || (c == CMD_READ);
  endfunction

endpackage

// File: rtl/at25010_interface_if.sv
// Command-side handshake bundle of the AT25010 SPI master.
//   master : system-side controller (drives request fields)
//   slave  : at25010_interface (drives ready/result/status pulses)
interface at25010_interface_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_type;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] cmd_rdata;
  logic       cmd_done;
  logic       cmd_error;

  modport master (
    output cmd_valid, cmd_type, cmd_addr, cmd_wdata,
    input  cmd_ready, cmd_rdata, cmd_done, cmd_error
  );

  modport slave (
    input  cmd_valid, cmd_type, cmd_addr, cmd_wdata,
    output cmd_ready, cmd_rdata, cmd_done, cmd_error
  );
endinterface

// File: rtl/at25010_spi_shifter.sv
// SPI mode-0 bit engine: CLOCK_DIV prescaler, 24-bit left-aligned shift
// register, 5-bit down-counting bit counter and MISO capture.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   run_i        prescaler enable (frame in progress)
//   load_i       load frame_i/len_i and restart the prescaler
//   frame_i      frame bits, MSB first, left-aligned
//   len_i        number of SCLK bits in the frame
//   shift_en_i   SCLK toggling allowed
//   miso_i       serial data from the EEPROM
//   tick_o       last clk cycle of the current half-period
//   sclk_o       SPI clock (idle low)
//   mosi_o       current MSB of the shift register
//   last_o       falling SCLK edge that ends the frame
//   rx_o         last 8 MISO bits, MSB first
module at25010_spi_shifter #(
  parameter int unsigned CLOCK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  input  logic        load_i,
  input  logic [23:0] frame_i,
  input  logic [4:0]  len_i,
  input  logic        shift_en_i,
  input  logic        miso_i,
  output logic        tick_o,
  output logic        sclk_o,
  output logic        mosi_o,
  output logic        last_o,
  output logic [7:0]  rx_o
);

  localparam int unsigned DW = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLOCK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [23:0]   sreg_q, sreg_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          sclk_q, sclk_d;
  logic [7:0]    rx_q, rx_d;

  assign tick_o = run_i && (div_q == DIV_LAST);
  assign sclk_o = sclk_q;
  assign mosi_o = sreg_q[23];
  assign rx_o   = rx_q;
  // Counter already hit zero on the final rising edge; this is its falling edge
  assign last_o = shift_en_i && tick_o && sclk_q && (cnt_q == '0);

  always_comb begin
    div_d  = div_q;
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    rx_d   = rx_q;

    if (!run_i || load_i || tick_o) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end

    if (load_i) begin
      sreg_d = frame_i;
      cnt_d  = len_i;
      sclk_d = 1'b0;
    end else if (shift_en_i && tick_o) begin
      if (!sclk_q) begin
        // Rising edge: capture MISO and consume one bit
        sclk_d = 1'b1;
        rx_d   = {rx_q[6:0], miso_i};
        cnt_d  = cnt_q - 1'b1;
      end else begin
        // Falling edge: present the next MOSI bit
        sclk_d = 1'b0;
        sreg_d = {sreg_q[22:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      sreg_q <= '0;
      cnt_q  <= '0;
      sclk_q <= 1'b0;
      rx_q   <= '0;
    end else begin
      div_q  <= div_d;
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
      rx_q   <= rx_d;
    end
  end

endmodule

// File: rtl/at25010_interface.sv
// Single-command SPI master for an AT25010 (128 x 8) serial EEPROM.
// Accepts one abstract command over a valid/ready handshake, serialises it
// as one SPI mode-0 frame and reports completion/rejection with pulses.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   cmd          command handshake bundle (slave side)
//   spi_cs_n     chip select, active low
//   spi_sclk     SPI clock, idle low
//   spi_mosi     master out (0 while reading)
//   spi_miso     master in
module at25010_interface
  import at25010_interface_pkg::*;
#(
  parameter int unsigned CLOCK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  at25010_interface_if.slave   cmd,
  output logic                 spi_cs_n,
  output logic                 spi_sclk,
  output logic                 spi_mosi,
  input  logic                 spi_miso
);

  state_e      state_q, state_d;
  cmd_e        type_q, type_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;

  logic [23:0] frame;
  logic [4:0]  frame_len;
  logic        type_ok;
  logic        load;
  logic        run;
  logic        shift_en;
  logic        tick;
  logic        last;
  logic        shift_mosi;
  logic [7:0]  rx;

  // Frame assembly from the live request; cmd_addr/cmd_wdata are held by
  // the shift register from the accept edge onwards.
  always_comb begin
    frame     = '0;
    frame_len = '0;
    type_ok   = 1'b1;
    case (cmd.cmd_type)
      CMD_WREN: begin
        frame     = {OP_WREN, 16'h0000};
        frame_len = LEN_OP;
      end
      CMD_WRDI: begin
        frame     = {OP_WRDI, 16'h0000};
        frame_len = LEN_OP;
      end
      CMD_RDSR: begin
        frame     = {OP_RDSR, 16'h0000};
        frame_len = LEN_OP_B1;
      end
      CMD_WRSR: begin
        frame     = {OP_WRSR, cmd.cmd_wdata, 8'h00};
        frame_len = LEN_OP_B1;
      end
      CMD_READ: begin
        frame     = {OP_READ, 1'b0, cmd.cmd_addr, 8'h00};
        frame_len = LEN_OP_B2;
      end
      CMD_WRITE: begin
        frame     = {OP_WRITE, 1'b0, cmd.cmd_addr, cmd.cmd_wdata};
        frame_len = LEN_OP_B2;
      end
      default: type_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    load    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd.cmd_valid) begin
          type_d = cmd_e'(cmd.cmd_type);
          if (type_ok) begin
            load    = 1'b1;
            state_d = ST_CS_SETUP;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_CS_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT:    if (last) state_d = ST_CS_HOLD;
      ST_CS_HOLD:  if (tick) state_d = ST_CS_GAP;
      ST_CS_GAP: begin
        if (tick) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          if (is_read_cmd(type_q)) rdata_d = rx;
        end
      end
      ST_ERR:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      type_q  <= CMD_WREN;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign run      = (state_q != ST_IDLE) && (state_q != ST_ERR);
  assign shift_en = (state_q == ST_SHIFT);

  at25010_spi_shifter #(
    .CLOCK_DIV (CLOCK_DIV)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run),
    .load_i     (load),
    .frame_i    (frame),
    .len_i      (frame_len),
    .shift_en_i (shift_en),
    .miso_i     (spi_miso),
    .tick_o     (tick),
    .sclk_o     (spi_sclk),
    .mosi_o     (shift_mosi),
    .last_o     (last),
    .rx_o       (rx)
  );

  assign spi_cs_n = !((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT) ||
                      (state_q == ST_CS_HOLD));
  // Shift register keeps residual bits after the frame; only drive them
  // while the frame is actually on the wire.
  assign spi_mosi = ((state_q == ST_CS_SETUP) || (state_q == ST_SHIFT)) ?
                    shift_mosi : 1'b0;

  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.cmd_error = (state_q == ST_ERR);
  assign cmd.cmd_done  = done_q;
  assign cmd.cmd_rdata = rdata_q;

endmodule

// File: tb/tb_at25010_interface.sv
// Directed self-checking bench for at25010_interface with a behavioural
// AT25010 model (status WEL + BP bits, 128-byte memory initialised to 0xFF).
module tb_at25010_interface;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_cs_n;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso = 1'b0;

  at25010_interface_if cmd_if ();

  at25010_interface #(
    .CLOCK_DIV (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_if),
    .spi_cs_n (spi_cs_n),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso)
  );

  always #5 clk = ~clk;

  // ---------------- EEPROM model ----------------
  logic [7:0]  mem [128] = '{default: 8'hFF};
  logic [1:0]  bp = 2'b00;
  logic        wel = 1'b0;
  int          bitn = 0;
  int          rises = 0;
  logic [7:0]  shin = 8'h00;
  logic [7:0]  op = 8'hFF;
  logic [7:0]  b2 = 8'h00;
  logic [7:0]  b3 = 8'h00;
  logic [31:0] mosi_log = 32'h0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;
  logic [7:0]  outb;

  always @(posedge spi_cs_n or negedge spi_cs_n or posedge spi_sclk or negedge spi_sclk) begin
    if (spi_cs_n !== cs_prev) begin
      if (spi_cs_n === 1'b0) begin
        bitn = 0; rises = 0; op = 8'hFF; mosi_log = 32'h0;
      end else begin
        if (op == 8'h06 && bitn == 8) wel = 1'b1;
        if (op == 8'h04 && bitn == 8) wel = 1'b0;
        if (op == 8'h01 && bitn == 16 && wel) begin bp = b2[3:2]; wel = 1'b0; end
        if (op == 8'h02 && bitn == 24 && wel) begin mem[b2[6:0]] = b3; wel = 1'b0; end
      end
    end else if (spi_sclk !== sclk_prev && spi_cs_n === 1'b0) begin
      if (spi_sclk === 1'b1) begin
        shin = {shin[6:0], spi_mosi};
        mosi_log = {mosi_log[30:0], spi_mosi};
        bitn++; rises++;
        if (bitn == 8)  op = shin;
        if (bitn == 16) b2 = shin;
        if (bitn == 24) b3 = shin;
      end else begin
        spi_miso = 1'b0;
        if (op == 8'h05 && bitn >= 8 && bitn < 16) begin
          outb = {4'b0000, bp, wel, 1'b0};
          spi_miso = outb[15 - bitn];
        end
        if (op == 8'h03 && bitn >= 16 && bitn < 24) begin
          outb = mem[b2[6:0]];
          spi_miso = outb[23 - bitn];
        end
      end
    end
    cs_prev = spi_cs_n;
    sclk_prev = spi_sclk;
  end

  // ---------------- monitors ----------------
  int   done_cnt = 0;
  int   err_cnt = 0;
  logic cs_low_seen = 1'b0;
  logic cs_mon_clr = 1'b0;

  always @(posedge clk) begin
    if (cmd_if.cmd_done === 1'b1) done_cnt++;
    if (cmd_if.cmd_error === 1'b1) err_cnt++;
    if (cs_mon_clr) cs_low_seen = 1'b0;
    else if (spi_cs_n === 1'b0) cs_low_seen = 1'b1;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_cmd(input logic [2:0] t, input logic [6:0] a, input logic [7:0] d,
                        output int unsigned cyc);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_type  = t;
    cmd_if.cmd_addr  = a;
    cmd_if.cmd_wdata = d;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    chk("ready_busy", {31'b0, cmd_if.cmd_ready}, 32'd0);
    cyc = 0;
    while (cmd_if.cmd_done !== 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", {31'b0, cmd_if.cmd_done}, 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned cyc;
    int d0;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_type  = 3'b000;
    cmd_if.cmd_addr  = 7'h00;
    cmd_if.cmd_wdata = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    chk("rst_done",  {31'b0, cmd_if.cmd_done},  32'd0);
    chk("rst_error", {31'b0, cmd_if.cmd_error}, 32'd0);
    chk("rst_rdata", {24'b0, cmd_if.cmd_rdata}, 32'h00);
    chk("rst_cs_n",  {31'b0, spi_cs_n}, 32'd1);
    chk("rst_sclk",  {31'b0, spi_sclk}, 32'd0);
    chk("rst_mosi",  {31'b0, spi_mosi}, 32'd0);
    rst = 1'b0;

    // RDSR on fresh device: 4 setup + 16*8 shift + 4 hold + 4 gap = 140 cycles
    do_cmd(3'b010, 7'h00, 8'h00, cyc);
    chk("rdsr0_rdata", {24'b0, cmd_if.cmd_rdata}, 32'h00);
    chk("rdsr0_edges", rises, 32'd16);
    chk("rdsr0_cs_n",  {31'b0, spi_cs_n}, 32'd1);
    chk("rdsr0_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    chk("rdsr0_lat",   cyc, 32'd141);
    chk("rdsr0_mosi",  mosi_log, 32'h0500);

    // WREN frame and WEL readback
    do_cmd(3'b000, 7'h00, 8'h00, cyc);
    chk("wren_mosi",  mosi_log, 32'h06);
    chk("wren_edges", rises, 32'd8);
    chk("wren_rdata_held", {24'b0, cmd_if.cmd_rdata}, 32'h00);
    do_cmd(3'b010, 7'h00, 8'h00, cyc);
    chk("rdsr_wel", {24'b0, cmd_if.cmd_rdata}, 32'h02);
    do_cmd(3'b001, 7'h00, 8'h00, cyc);
    chk("wrdi_mosi", mosi_log, 32'h04);
    chk("wrdi_rdata_held", {24'b0, cmd_if.cmd_rdata}, 32'h02);
    do_cmd(3'b010, 7'h00, 8'h00, cyc);
    chk("rdsr_nowel", {24'b0, cmd_if.cmd_rdata}, 32'h00);

    // WRITE / READ at 0x15
    do_cmd(3'b000, 7'h00, 8'h00, cyc);
    do_cmd(3'b101, 7'h15, 8'hA5, cyc);
    chk("write15_mosi", mosi_log, 32'h0215A5);
    repeat (50) @(negedge clk);
    do_cmd(3'b100, 7'h15, 8'h00, cyc);
    chk("read15_rdata", {24'b0, cmd_if.cmd_rdata}, 32'hA5);
    chk("read15_edges", rises, 32'd24);
    chk("read15_mosi",  mosi_log, 32'h031500);

    // Addresses 0..7
    for (int i = 0; i < 8; i++) begin
      do_cmd(3'b000, 7'h00, 8'h00, cyc);
      do_cmd(3'b101, 7'(i), 8'(8'h10 + i), cyc);
      repeat (50) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      do_cmd(3'b100, 7'(i), 8'h00, cyc);
      chk("read_lo", {24'b0, cmd_if.cmd_rdata}, 32'(8'h10 + i));
    end

    // Address boundaries
    do_cmd(3'b000, 7'h00, 8'h00, cyc);
    do_cmd(3'b101, 7'h00, 8'hAA, cyc);
    repeat (50) @(negedge clk);
    do_cmd(3'b100, 7'h00, 8'h00, cyc);
    chk("read00", {24'b0, cmd_if.cmd_rdata}, 32'hAA);
    do_cmd(3'b000, 7'h00, 8'h00, cyc);
    do_cmd(3'b101, 7'h7F, 8'h55, cyc);
    chk("write7f_addr", {24'b0, mosi_log[15:8]}, 32'h7F);
    repeat (50) @(negedge clk);
    do_cmd(3'b100, 7'h7F, 8'h00, cyc);
    chk("read7f", {24'b0, cmd_if.cmd_rdata}, 32'h55);
    chk("read7f_addr", {24'b0, mosi_log[15:8]}, 32'h7F);

    // Invalid command
    @(negedge clk);
    cs_mon_clr = 1'b1;
    @(negedge clk);
    cs_mon_clr = 1'b0;
    d0 = done_cnt;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_type  = 3'b110;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    chk("inv_error", {31'b0, cmd_if.cmd_error}, 32'd1);
    chk("inv_busy",  {31'b0, cmd_if.cmd_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("inv_error_end", {31'b0, cmd_if.cmd_error}, 32'd0);
    chk("inv_ready",     {31'b0, cmd_if.cmd_ready}, 32'd1);
    repeat (10) @(negedge clk);
    chk("inv_no_cs",   {31'b0, cs_low_seen}, 32'd0);
    chk("inv_no_done", done_cnt - d0, 32'd0);
    chk("inv_err_cnt", err_cnt, 32'd1);

    // WRSR
    do_cmd(3'b000, 7'h00, 8'h00, cyc);
    do_cmd(3'b011, 7'h00, 8'h0C, cyc);
    chk("wrsr_mosi", mosi_log, 32'h010C);
    do_cmd(3'b010, 7'h00, 8'h00, cyc);
    chk("rdsr_bp", {24'b0, cmd_if.cmd_rdata}, 32'h0C);

    // Reset in the middle of a READ
    @(negedge clk);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_type  = 3'b100;
    cmd_if.cmd_addr  = 7'h15;
    @(posedge clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    repeat (60) @(negedge clk);
    chk("mid_cs_low", {31'b0, spi_cs_n}, 32'd0);
    d0 = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_cs_n",  {31'b0, spi_cs_n}, 32'd1);
    chk("abort_sclk",  {31'b0, spi_sclk}, 32'd0);
    chk("abort_ready", {31'b0, cmd_if.cmd_ready}, 32'd1);
    chk("abort_done",  {31'b0, cmd_if.cmd_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_done", done_cnt - d0, 32'd0);

    // Recovery after abort
    do_cmd(3'b010, 7'h00, 8'h00, cyc);
    chk("recover_rdsr", {24'b0, cmd_if.cmd_rdata}, 32'h0C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
